// File: rtl/if_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction-fetch prefetch buffer.
package if_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] IMEM_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] IF_BOOT_ADDR    = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & IMEM_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Instruction-memory fetch bus: req/gnt address phase, in-order rvalid data phase.
interface if_prefetch_buffer_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_prefetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with flush; used for PC tags and for buffered instructions.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           data_i,
    input  logic                   pop_i,
    output fetch_entry_t           data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push_i & ~flush_i;
    assign do_pop_s  = pop_i & ~flush_i & ~empty_o;

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= fetch_entry_t'(64'h0);
            end
        end else if (flush_i) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_r + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
        end
    end

    assign data_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;
    assign empty_o = (count_r == (AW+1)'(0));
    assign full_o  = (count_r == (AW+1)'(DEPTH));

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited fetch issue, in-order buffering, redirect flush.
// Optional IF_PREFETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module if_prefetch_buffer
    import if_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = IF_BOOT_ADDR
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        redirect_i,
    input  logic [31:0]                 redirect_addr_i,
    if_prefetch_buffer_if.master        imem,
    output logic                        instr_valid_o,
    output logic [31:0]                 instr_o,
    output logic [31:0]                 instr_pc_o,
    input  logic                        instr_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic          run_r;

    logic [CW-1:0] outstanding_nxt_s;
    logic [CW:0]   credit_sum_s;
    logic [CW-1:0] ibuf_count_s;
    logic [CW-1:0] tag_count_s;
    logic          gnt_fire_s;
    logic          drop_s;
    logic          bypass_s;
    logic          ibuf_push_s;
    logic          ibuf_pop_s;
    logic          ibuf_empty_s;
    logic          ibuf_full_s;
    logic          tag_empty_s;
    logic          tag_full_s;
    fetch_entry_t  tag_in_s;
    fetch_entry_t  tag_head_s;
    fetch_entry_t  ibuf_in_s;
    fetch_entry_t  ibuf_head_s;
    logic          unused_s;

    // Words in flight plus words buffered may never exceed the buffer size.
    assign credit_sum_s      = {1'b0, outstanding_r} + {1'b0, ibuf_count_s};
    assign imem.req          = run_r & (credit_sum_s < (CW+1)'(DEPTH));
    assign imem.addr         = fetch_pc_r;
    assign gnt_fire_s        = imem.req & imem.gnt;
    assign drop_s            = (discard_r != {CW{1'b0}});
    assign outstanding_nxt_s = outstanding_r + {{(CW-1){1'b0}}, gnt_fire_s}
                                             - {{(CW-1){1'b0}}, imem.rvalid};

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass_s = ibuf_empty_s & ~drop_s & imem.rvalid & ~redirect_i;
`else
    assign bypass_s = 1'b0;
`endif

    assign tag_in_s    = '{pc: fetch_pc_r, instr: 32'h0000_0000};
    assign ibuf_in_s   = '{pc: tag_head_s.pc, instr: imem.rdata};
    assign ibuf_push_s = imem.rvalid & ~drop_s & ~(bypass_s & instr_ready_i);
    assign ibuf_pop_s  = ~ibuf_empty_s & ~redirect_i & instr_ready_i;

    assign instr_valid_o = (~ibuf_empty_s | bypass_s) & ~redirect_i;
    assign instr_o       = bypass_s ? imem.rdata    : ibuf_head_s.instr;
    assign instr_pc_o    = bypass_s ? tag_head_s.pc : ibuf_head_s.pc;

    // Fetch PC, in-flight count and stale-response count; redirect overrides the PC advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_r    <= BOOT_ADDR;
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            run_r         <= 1'b0;
        end else begin
            run_r         <= 1'b1;
            outstanding_r <= outstanding_nxt_s;
            if (redirect_i) begin
                fetch_pc_r <= align_word(redirect_addr_i);
                discard_r  <= outstanding_nxt_s;
            end else begin
                if (gnt_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (imem.rvalid && drop_s) begin
                    discard_r <= discard_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // The tag queue is never flushed: every response, stale or not, retires its tag.
    if_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (1'b0),
        .push_i  (gnt_fire_s),
        .data_i  (tag_in_s),
        .pop_i   (imem.rvalid),
        .data_o  (tag_head_s),
        .count_o (tag_count_s),
        .empty_o (tag_empty_s),
        .full_o  (tag_full_s)
    );

    if_fifo #(.DEPTH(DEPTH)) u_ibuf_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect_i),
        .push_i  (ibuf_push_s),
        .data_i  (ibuf_in_s),
        .pop_i   (ibuf_pop_s),
        .data_o  (ibuf_head_s),
        .count_o (ibuf_count_s),
        .empty_o (ibuf_empty_s),
        .full_o  (ibuf_full_s)
    );

    assign unused_s = ^{tag_head_s.instr, tag_count_s, tag_empty_s, tag_full_s, ibuf_full_s};

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed bench for if_prefetch_buffer with a latency-programmable in-order memory responder.
module tb_if_prefetch_buffer;
`ifdef IF_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        redirect;
    logic [31:0] redir_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    if_prefetch_buffer_if imem ();

    if_prefetch_buffer #(.DEPTH(4), .BOOT_ADDR(32'h0000_0000)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .redirect_i      (redirect),
        .redirect_addr_i (redir_addr),
        .imem            (imem),
        .instr_valid_o   (instr_valid),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
        .instr_ready_i   (instr_ready)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_gnt = 0;
    int          n_acc = 0;
    int          lat   = 1;
    int          cyc   = 0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_pc   = 32'h0;
    logic [31:0] pa[$];
    int          pd[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F0F;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l, input logic g, input logic r);
        rstn = 1'b0; redirect = 1'b0; imem.gnt = 1'b0; instr_ready = 1'b0; lat = l;
        step(2);
        rstn = 1'b1; imem.gnt = g; instr_ready = r;
        step(1);
    endtask

    task automatic wait_valid(input int max_cyc);
        int k = 0;
        while (!instr_valid && k < max_cyc) begin
            step(1);
            k++;
        end
        chk_val("valid_seen", 32'(instr_valid), 32'd1);
    endtask

    // Memory responder: returns each granted word in order, lat cycles after its grant.
    initial begin
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pa.delete();
                pd.delete();
            end else if (imem.req && imem.gnt) begin
                pa.push_back(imem.addr);
                pd.push_back(cyc + lat);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (pd.size() > 0 && pd[0] <= cyc) begin
                imem.rvalid = 1'b1;
                imem.rdata  = imem_word(pa[0]);
                void'(pa.pop_front());
                void'(pd.pop_front());
            end else begin
                imem.rvalid = 1'b0;
                imem.rdata  = 32'h0;
            end
        end
    end

    // Reference stream: expected fetch addresses and delivered PCs, retargeted on redirect.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_addr = 32'h0;
                exp_pc   = 32'h0;
            end else begin
                if (imem.req && imem.gnt) begin
                    chk_val("imem_addr", imem.addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                    n_gnt++;
                end
                if (instr_valid && instr_ready) begin
                    chk_val("instr_pc", instr_pc, exp_pc);
                    chk_val("instr", instr, imem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_acc++;
                end
                if (redirect) begin
                    exp_addr = redir_addr & 32'hFFFF_FFFC;
                    exp_pc   = redir_addr & 32'hFFFF_FFFC;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; redirect = 1'b0; redir_addr = 32'h0; imem.gnt = 1'b0; instr_ready = 1'b0;
        step(2);
        chk_val("rst_req", 32'(imem.req), 32'd0);
        chk_val("rst_valid", 32'(instr_valid), 32'd0);
        chk_val("rst_instr", instr, 32'h0);
        chk_val("rst_pc", instr_pc, 32'h0);
        chk_val("rst_addr", imem.addr, 32'h0);

        // Streaming at one instruction per cycle.
        do_reset(1, 1'b1, 1'b1);
        n_acc = 0;
        step(10);
        chk_val("stream_cnt", 32'(n_acc), BYP ? 32'd9 : 32'd8);

        // Decode stalled: credit stops issue after DEPTH grants.
        do_reset(1, 1'b1, 1'b0);
        n_gnt = 0;
        step(8);
        chk_val("full_gnts", 32'(n_gnt), 32'd4);
        chk_val("full_req", 32'(imem.req), 32'd0);
        chk_val("full_valid", 32'(instr_valid), 32'd1);
        chk_val("full_pc", instr_pc, 32'h0);
        chk_val("full_instr", instr, imem_word(32'h0));
        instr_ready = 1'b1;
        n_acc = 0;
        step(1);
        chk_val("resume_req", 32'(imem.req), 32'd1);
        chk_val("resume_addr", imem.addr, 32'h10);
        step(4);
        chk_val("resume_cnt", 32'(n_acc), 32'd5);

        // Grant withheld: address stays put.
        do_reset(1, 1'b1, 1'b1);
        step(2);
        imem.gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_val("hold_addr", imem.addr, 32'h8);
            chk_val("hold_req", 32'(imem.req), 32'd1);
            step(1);
        end
        imem.gnt = 1'b1;
        step(3);

        // Redirect with three responses still in flight.
        do_reset(4, 1'b1, 1'b1);
        step(3);
        imem.gnt = 1'b0; redirect = 1'b1; redir_addr = 32'h0000_1003;
        chk_val("redir_valid", 32'(instr_valid), 32'd0);
        step(1);
        redirect = 1'b0; imem.gnt = 1'b1;
        chk_val("redir_addr", imem.addr, 32'h1000);
        chk_val("redir_req", 32'(imem.req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk_val("stale_valid", 32'(instr_valid), 32'd0);
            step(1);
        end
        wait_valid(20);
        chk_val("redir_first_pc", instr_pc, 32'h1000);
        step(3);

        // Back-to-back redirects, each in a cycle with both a grant and a response.
        do_reset(2, 1'b1, 1'b1);
        step(3);
        redirect = 1'b1; redir_addr = 32'h0000_2000;
        chk_val("r2_rvalid", 32'(imem.rvalid), 32'd1);
        step(1);
        redir_addr = 32'h0000_3000;
        chk_val("r2b_rvalid", 32'(imem.rvalid), 32'd1);
        step(1);
        redirect = 1'b0;
        chk_val("r2_valid", 32'(instr_valid), 32'd0);
        wait_valid(20);
        chk_val("r2_first_pc", instr_pc, 32'h3000);
        step(5);

        // First-word latency with an empty buffer.
        do_reset(1, 1'b1, 1'b1);
        step(1);
        chk_val("lat_valid1", 32'(instr_valid), BYP ? 32'd1 : 32'd0);
        step(1);
        chk_val("lat_valid2", 32'(instr_valid), 32'd1);
        chk_val("lat_pc2", instr_pc, BYP ? 32'h4 : 32'h0);
        step(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
